// File: rtl/td4_register_bank.sv
// ---------------------------------------------------------------------------
// td4_register_bank
//
// Architectural state of the TD4 4-bit CPU: registers A, B, OUT, the
// program counter and the carry flag, plus a two-flop synchronizer for the
// external input switches.
//
// Every register loads from the shared ALU sum `d` when its load strobe is
// asserted on an enabled cycle. Otherwise it holds its value. The exception
// is the PC, which increments modulo 2^WIDTH when it is not loaded. All
// outputs come straight from flops.
//
// Optional build macro:
//   TD4_STEP_EN - adds a `step` push-button input. The button passes through
//                 its own synchronizer and a rising-edge detector, so that
//                 exactly one instruction commits per press
//                 (effective enable = ce & step_rise).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high (beats ce and all ld_*)
//   ce         in   cycle enable (synchronizer runs regardless)
//   d          in   ALU sum, load data for every register
//   alu_carry  in   ALU carry-out, captured into c_flag on enabled cycles
//   ld_a       in   load A from d
//   ld_b       in   load B from d
//   ld_out     in   load OUT from d
//   ld_pc      in   load PC from d (jump), else PC increments
//   in_port    in   asynchronous input switches
//   step       in   asynchronous step button (TD4_STEP_EN only)
//   a_q        out  register A
//   b_q        out  register B
//   in_q       out  synchronized in_port
//   out_q      out  output port register
//   pc_q       out  program counter
//   c_flag     out  registered carry flag
// ---------------------------------------------------------------------------
module td4_register_bank #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             alu_carry,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             ld_out,
  input  logic             ld_pc,
  input  logic [WIDTH-1:0] in_port,
`ifdef TD4_STEP_EN
  input  logic             step,
`endif
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] in_q,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] pc_q,
  output logic             c_flag
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic             en;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] pc_d;
  logic             c_flag_d;
  logic [WIDTH-1:0] s1_q;

`ifdef TD4_STEP_EN
  logic step_s1_q;
  logic step_s2_q;
  logic step_prev_q;
  logic step_rise;

  // Synchronize the step button and remember its previous synchronized level.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_s1_q   <= step;
      step_s2_q   <= step_s1_q;
      step_prev_q <= step_s2_q;
    end
  end

  // A single-cycle pulse on the synchronized 0->1 transition, so a held button
  // yields only one step.
  always_comb begin
    step_rise = step_s2_q & ~step_prev_q;
    en        = ce & step_rise;
  end
`else
  // Without the step button the cycle enable is used directly.
  always_comb begin
    en = ce;
  end
`endif

  // Next-state selection for the architectural registers.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    pc_d     = pc_q;
    c_flag_d = c_flag;
    if (en) begin
      // All asserted strobes load the same d in the same cycle.
      if (ld_a) begin
        a_d = d;
      end else begin
        a_d = a_q;
      end
      if (ld_b) begin
        b_d = d;
      end else begin
        b_d = b_q;
      end
      if (ld_out) begin
        out_d = d;
      end else begin
        out_d = out_q;
      end
      if (ld_pc) begin
        pc_d = d;
      end else begin
        pc_d = pc_q + ONE;  // wraps naturally at 2^WIDTH
      end
      c_flag_d = alu_carry;
    end else begin
      a_d      = a_q;
      b_d      = b_q;
      out_d    = out_q;
      pc_d     = pc_q;
      c_flag_d = c_flag;
    end
  end

  // Architectural state registers. Reset discards any in-flight loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= ZERO;
      b_q    <= ZERO;
      out_q  <= ZERO;
      pc_q   <= PC_RESET;
      c_flag <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      pc_q   <= pc_d;
      c_flag <= c_flag_d;
    end
  end

  // Two-flop synchronizer for the input switches. It runs every cycle,
  // independent of the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= ZERO;
      in_q <= ZERO;
    end else begin
      s1_q <= in_port;
      in_q <= s1_q;
    end
  end

endmodule

// File: tb/tb_td4_register_bank.sv
module tb_td4_register_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [3:0] d;
  logic       alu_carry;
  logic       ld_a;
  logic       ld_b;
  logic       ld_out;
  logic       ld_pc;
  logic [3:0] in_port;
`ifdef TD4_STEP_EN
  logic       step;
`endif
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] in_q;
  logic [3:0] out_q;
  logic [3:0] pc_q;
  logic       c_flag;

  int checks   = 0;
  int failures = 0;

  td4_register_bank #(.WIDTH(4), .PC_RESET(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .d         (d),
    .alu_carry (alu_carry),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_out    (ld_out),
    .ld_pc     (ld_pc),
    .in_port   (in_port),
`ifdef TD4_STEP_EN
    .step      (step),
`endif
    .a_q       (a_q),
    .b_q       (b_q),
    .in_q      (in_q),
    .out_q     (out_q),
    .pc_q      (pc_q),
    .c_flag    (c_flag)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; d = 4'h5; alu_carry = 1'b1;
    ld_a = 1'b1; ld_b = 1'b1; ld_out = 1'b1; ld_pc = 1'b1; in_port = 4'hA;
    tick();
    checks++;
    if ({a_q, b_q, out_q, pc_q, in_q, c_flag} !== 21'h0) begin
      failures++;
      $display("FAIL reset_first a=%h b=%h out=%h pc=%h in=%h c=%b expected all 0",
               a_q, b_q, out_q, pc_q, in_q, c_flag);
    end
    tick();
    checks++;
    if ({a_q, b_q, out_q, pc_q, in_q, c_flag} !== 21'h0) begin
      failures++;
      $display("FAIL reset_second a=%h b=%h out=%h pc=%h in=%h c=%b expected all 0",
               a_q, b_q, out_q, pc_q, in_q, c_flag);
    end
    rst = 1'b0; ld_a = 1'b0; ld_b = 1'b0; ld_out = 1'b0; ld_pc = 1'b0; alu_carry = 1'b0;
    tick();
    checks++;
    if (in_q !== 4'h0) begin
      failures++;
      $display("FAIL sync_latency1 in_q=%h expected 0", in_q);
    end
    tick();
    checks++;
    if (in_q !== 4'hA) begin
      failures++;
      $display("FAIL sync_latency2 in_q=%h expected a", in_q);
    end
  endtask

`ifndef TD4_STEP_EN
  task automatic test_increment_wrap();
    logic [3:0] exp_pc;
    rst = 1'b1; ce = 1'b1; d = 4'h0; alu_carry = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0; ld_out = 1'b0; ld_pc = 1'b0;
    tick();
    checks++;
    if (pc_q !== 4'h0) begin
      failures++;
      $display("FAIL inc_start pc=%h expected 0", pc_q);
    end
    rst = 1'b0;
    exp_pc = 4'h0;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp_pc = exp_pc + 4'h1;
      checks++;
      if (pc_q !== exp_pc || {a_q, b_q, out_q} !== 12'h000) begin
        failures++;
        $display("FAIL inc_wrap step %0d pc=%h a=%h b=%h out=%h expected pc=%h regs 0",
                 i, pc_q, a_q, b_q, out_q, exp_pc);
      end
    end
  endtask

  task automatic test_loads();
    d = 4'h3; ld_a = 1'b1;
    tick();
    checks++;
    if (a_q !== 4'h3) begin
      failures++;
      $display("FAIL load_a a=%h expected 3", a_q);
    end
    d = 4'h9; ld_a = 1'b0; ld_b = 1'b1; ld_out = 1'b1;
    tick();
    checks++;
    if (b_q !== 4'h9 || out_q !== 4'h9 || a_q !== 4'h3) begin
      failures++;
      $display("FAIL load_b_out b=%h out=%h a=%h expected b=9 out=9 a=3", b_q, out_q, a_q);
    end
    ld_b = 1'b0; ld_out = 1'b0;
  endtask

  task automatic test_jump_carry();
    d = 4'h7; ld_pc = 1'b1; alu_carry = 1'b1;
    tick();
    checks++;
    if (pc_q !== 4'h7 || c_flag !== 1'b1) begin
      failures++;
      $display("FAIL jump pc=%h c=%b expected pc=7 c=1", pc_q, c_flag);
    end
    ld_pc = 1'b0; alu_carry = 1'b0;
    tick();
    checks++;
    if (pc_q !== 4'h8 || c_flag !== 1'b0) begin
      failures++;
      $display("FAIL after_jump pc=%h c=%b expected pc=8 c=0", pc_q, c_flag);
    end
  endtask

  task automatic test_hold();
    ce = 1'b0; ld_a = 1'b1; d = 4'hF; alu_carry = 1'b1; in_port = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_q !== 4'h3 || pc_q !== 4'h8 || c_flag !== 1'b0 || b_q !== 4'h9 || out_q !== 4'h9) begin
        failures++;
        $display("FAIL hold cycle %0d a=%h b=%h out=%h pc=%h c=%b expected a=3 b=9 out=9 pc=8 c=0",
                 i, a_q, b_q, out_q, pc_q, c_flag);
      end
      if (i == 0) begin
        checks++;
        if (in_q !== 4'hA) begin
          failures++;
          $display("FAIL hold_sync1 in_q=%h expected a", in_q);
        end
      end else begin
        checks++;
        if (in_q !== 4'h5) begin
          failures++;
          $display("FAIL hold_sync%0d in_q=%h expected 5", i + 1, in_q);
        end
      end
    end
    ld_a = 1'b0; alu_carry = 1'b0;
  endtask

  task automatic test_simultaneous();
    ce = 1'b1; d = 4'hC; ld_a = 1'b1; ld_b = 1'b1; ld_out = 1'b1; ld_pc = 1'b1;
    tick();
    checks++;
    if (a_q !== 4'hC || b_q !== 4'hC || out_q !== 4'hC || pc_q !== 4'hC) begin
      failures++;
      $display("FAIL simultaneous a=%h b=%h out=%h pc=%h expected all c", a_q, b_q, out_q, pc_q);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; ce = 1'b1; d = 4'hF; alu_carry = 1'b1;
    ld_a = 1'b1; ld_b = 1'b1; ld_out = 1'b1; ld_pc = 1'b1;
    tick();
    checks++;
    if ({a_q, b_q, out_q, pc_q, in_q, c_flag} !== 21'h0) begin
      failures++;
      $display("FAIL reset_priority a=%h b=%h out=%h pc=%h in=%h c=%b expected all 0",
               a_q, b_q, out_q, pc_q, in_q, c_flag);
    end
    rst = 1'b0; ld_a = 1'b0; ld_b = 1'b0; ld_out = 1'b0; ld_pc = 1'b0; alu_carry = 1'b0;
  endtask
`else
  task automatic test_step();
    logic [3:0] start_pc;
    rst = 1'b1; ce = 1'b1; step = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0; ld_out = 1'b0; ld_pc = 1'b0; alu_carry = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc_q !== 4'h0) begin
      failures++;
      $display("FAIL step_idle pc=%h expected 0", pc_q);
    end
    start_pc = pc_q;
    step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pc_q !== start_pc + 4'h1) begin
      failures++;
      $display("FAIL step_press1 pc=%h expected %h", pc_q, start_pc + 4'h1);
    end
    step = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pc_q !== start_pc + 4'h2) begin
      failures++;
      $display("FAIL step_press2 pc=%h expected %h", pc_q, start_pc + 4'h2);
    end
    step = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef TD4_STEP_EN
    step = 1'b0;
`endif
    test_reset();
`ifndef TD4_STEP_EN
    test_increment_wrap();
    test_loads();
    test_jump_carry();
    test_hold();
    test_simultaneous();
    test_reset_priority();
`else
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/td4_register_bank.md
Name: td4_register_bank

Overview:
- Architectural state for the 4-bit CPU: registers A, B, OUT, PC and the carry flag.
- Sits directly upstream of the 2-bit-select operand selector. It provides the A, B and synchronized IN values that the selector chooses between.
- Sits downstream of the ALU adder. It loads the ALU sum into whichever registers the decoder enables.
- Also synchronizes the external input switches.

Parameters:
- WIDTH, 4, bit width of A, B, OUT, PC, d and in_port.
- PC_RESET, 0, value loaded into PC on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- ce  input  1  cycle enable; when 0, no register, PC or flag changes (synchronizer still runs).
- d  input  WIDTH  ALU sum; load data for every register.
- alu_carry  input  1  ALU carry-out of the current instruction.
- ld_a  input  1  load A from d.
- ld_b  input  1  load B from d.
- ld_out  input  1  load OUT from d.
- ld_pc  input  1  load PC from d (jump); otherwise PC increments.
- in_port  input  WIDTH  asynchronous external switches.
- a_q  output  WIDTH  register A.
- b_q  output  WIDTH  register B.
- in_q  output  WIDTH  synchronized in_port.
- out_q  output  WIDTH  output port register.
- pc_q  output  WIDTH  program counter (instruction ROM address).
- c_flag  output  1  registered carry flag, consumed by the decoder for conditional jump.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: on a clk edge with rst=1, a_q=0, b_q=0, out_q=0, pc_q=PC_RESET, c_flag=0. Both synchronizer stages are cleared to 0, so in_q=0.
- Reset priority: rst has priority over ce and over every ld_*. Reset asserted mid-instruction discards that instruction's loads.
- Synchronizer: in_port passes through a 2-flop synchronizer (s1 <= in_port; in_q <= s1). It updates every cycle regardless of ce. Latency from in_port to in_q is 2 cycles.
- Enabled cycle (rst=0, ce=1):
  - A, B and OUT each load d when their ld_* is 1, else hold.
  - PC <= d if ld_pc=1, else PC <= pc_q + 1, modulo 2^WIDTH (wraps 4'hF -> 4'h0).
  - c_flag <= alu_carry.
- Simultaneous loads: all asserted ld_* take effect in the same cycle with the same d. There is no priority among them and no error.
- Disabled cycle (ce=0): a_q, b_q, out_q, pc_q and c_flag all hold; ld_* and alu_carry are ignored.
- Timing: all outputs are registered. A write is visible on the outputs 1 cycle after the enabled edge. There is no combinational path from inputs to outputs.
- Self-referencing loads: d may combinationally depend on a_q/b_q (e.g. ADD A,Im). The new value is taken at the edge, so there is no loop.

Optional Feature:
- Macro: TD4_STEP_EN.
- With the macro defined:
  - Adds input step (1 bit, asynchronous push button).
  - step passes through its own 2-flop synchronizer plus a rising-edge detector.
  - The effective enable is ce AND step_rise, so exactly one instruction commits per button press.
  - A held button produces only one step. The step synchronizer and edge-detector flops reset to 0.
- Without the macro: no step port; the effective enable is ce.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_port=4'hA and all ld_*=1, d=4'h5 -> all outputs read 0 (pc_q=PC_RESET) the cycle after the first reset edge. After release, in_q=4'hA on the 2nd enabled edge.
- Increment and wrap: ce=1, no loads, run 17 cycles from reset -> pc_q sequence 0,1,...,F,0,1; a_q/b_q/out_q stay 0.
- Loads: d=4'h3 with ld_a=1 -> a_q=3 next cycle. Then d=4'h9 with ld_b=1, ld_out=1 -> b_q=9, out_q=9, a_q remains 3.
- Jump and carry: d=4'h7, ld_pc=1, alu_carry=1 -> pc_q=7, c_flag=1. The next cycle with alu_carry=0, no load -> pc_q=8, c_flag=0.
- Hold: ce=0 for 3 cycles with ld_a=1, d=4'hF, alu_carry=1 -> a_q, pc_q and c_flag unchanged. in_q still tracks a change of in_port after 2 cycles.
- TD4_STEP_EN: ce=1, step held high for 10 cycles -> pc_q advances by exactly 1. Release then press again -> pc_q advances by 1 more.
